// File: rtl/inbuf_fifo.sv
// inbuf_fifo: multi-entry input skid buffer between an upstream producer and a core.
// Upstream and core both use a valid/stop handshake. istop is derived only from state
// (plus reset/flush), so there is no combinational path from cstop to istop.
// With BYPASS=1, a beat arriving at an empty buffer may go straight to the core.

module inbuf_fifo #(
    parameter int W      = 16,
    parameter int DEPTH  = 4,
    parameter int BYPASS = 1,
    parameter int AFULL  = 3
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic [W-1:0]                 idata,
    input  logic                         ivalid,
    output logic                         istop,
    output logic [W-1:0]                 cdata,
    output logic                         cvalid,
    input  logic                         cstop,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         afull
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rdptr;
    logic [AW-1:0] wrptr;
    logic          empty;
    logic          full;
    logic          bypassing;
    logic          push;
    logic          pop;

    // Handshake decode: output selection, stop to upstream, and push/pop strobes.
    // A bypassing beat that the core takes immediately is never written to storage.
    always_comb begin
        empty     = (count == '0);
        full      = (count == CW'(DEPTH));
        bypassing = (BYPASS != 0) && empty;
        istop     = reset | flush | full;
        cvalid    = 1'b0;
        cdata     = mem[rdptr];
        if (!reset && !flush) begin
            if (!empty) begin
                cvalid = 1'b1;
            end else if (bypassing) begin
                cvalid = ivalid;
            end
        end
        if (bypassing) begin
            cdata = idata;
        end
        push = ivalid && !istop && !(bypassing && !cstop);
        pop  = !empty && cvalid && !cstop;
    end

    assign afull = (count >= CW'(AFULL));

    // Pointer and occupancy state. Reset beats flush, flush beats any transfer.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rdptr <= '0;
            wrptr <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wrptr <= wrptr + AW'(1);
            end
            if (pop) begin
                rdptr <= rdptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array; intentionally not cleared by reset, since entries past count are never read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wrptr] <= idata;
        end
    end

endmodule

// File: tb/tb_inbuf_fifo.sv
// Self-checking bench for inbuf_fifo: a bypass instance takes most of the directed
// vectors plus a randomised order check, and a registered instance covers the latency-1 path.

module tb_inbuf_fifo;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic [15:0] idata;
    logic        ivalid;
    logic        istop;
    logic [15:0] cdata;
    logic        cvalid;
    logic        cstop;
    logic [2:0]  count;
    logic        afull;

    logic        flush0;
    logic [15:0] idata0;
    logic        ivalid0;
    logic        istop0;
    logic [15:0] cdata0;
    logic        cvalid0;
    logic        cstop0;
    logic [2:0]  count0;
    logic        afull0;

    int checks = 0;
    int errors = 0;

    inbuf_fifo #(.W(16), .DEPTH(4), .BYPASS(1), .AFULL(3)) dut (
        .clk(clk), .reset(reset), .flush(flush), .idata(idata), .ivalid(ivalid),
        .istop(istop), .cdata(cdata), .cvalid(cvalid), .cstop(cstop),
        .count(count), .afull(afull)
    );

    inbuf_fifo #(.W(16), .DEPTH(4), .BYPASS(0), .AFULL(3)) dut0 (
        .clk(clk), .reset(reset), .flush(flush0), .idata(idata0), .ivalid(ivalid0),
        .istop(istop0), .cdata(cdata0), .cvalid(cvalid0), .cstop(cstop0),
        .count(count0), .afull(afull0)
    );

    always #5 clk = ~clk;

    // Compare one observed value against its expectation and count the result.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive the upstream and core-side inputs of the bypass instance.
    task automatic applyStimulus(input logic v, input logic [15:0] d, input logic s);
        ivalid = v;
        idata  = d;
        cstop  = s;
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Fill three entries, discard them with flush or reset, then prove only the new beat comes out.
    task automatic discardTest(input bit useReset);
        applyStimulus(1'b1, 16'h0011, 1'b1); tick();
        applyStimulus(1'b1, 16'h0022, 1'b1); tick();
        applyStimulus(1'b1, 16'h0033, 1'b1); tick();
        applyStimulus(1'b1, 16'h0077, 1'b1);
        #1;
        checkOutput("disc_count_before", count, 3);
        if (useReset) reset = 1'b1; else flush = 1'b1;
        #1;
        checkOutput("disc_istop", istop, 1);
        checkOutput("disc_cvalid", cvalid, 0);
        tick();
        reset = 1'b0;
        flush = 1'b0;
        #1;
        checkOutput("disc_count_after", count, 0);
        checkOutput("disc_afull_after", afull, 0);
        checkOutput("disc_istop_after", istop, 0);
        tick();
        applyStimulus(1'b0, 16'h0000, 1'b0);
        #1;
        checkOutput("disc_cvalid_out", cvalid, 1);
        checkOutput("disc_cdata_out", cdata, 16'h0077);
        checkOutput("disc_count_one", count, 1);
        tick();
        #1;
        checkOutput("disc_cvalid_end", cvalid, 0);
        checkOutput("disc_count_end", count, 0);
    endtask

    logic [15:0] expOut [5];
    int          expCnt [5];
    logic        expStop[5];
    logic [15:0] sb[$];
    logic [15:0] word;
    logic        pending;
    int          sent;
    int          received;
    int          cycles;
    bit          acc;
    bit          outb;

    initial begin
        reset = 1'b1; flush = 1'b0;
        applyStimulus(1'b0, 16'h0000, 1'b0);
        flush0 = 1'b0; ivalid0 = 1'b0; idata0 = 16'h0000; cstop0 = 1'b0;
        tick();
        #1;
        checkOutput("rst_istop", istop, 1);
        checkOutput("rst_cvalid", cvalid, 0);
        checkOutput("rst_count", count, 0);
        checkOutput("rst_afull", afull, 0);
        checkOutput("rst_count0", count0, 0);
        tick();
        reset = 1'b0;
        #1;
        checkOutput("rel_istop", istop, 0);

        // Zero-latency pass-through while empty and the core is ready.
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1'b1, 16'(i), 1'b0);
            #1;
            checkOutput("byp_cdata", cdata, 32'(i));
            checkOutput("byp_cvalid", cvalid, 1);
            checkOutput("byp_count", count, 0);
            checkOutput("byp_istop", istop, 0);
            tick();
        end

        // Fill against a stopped core: counts 0..4, afull from 3, istop at 4 with A4 held.
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b1, 16'h00A0 + 16'(k < 4 ? k : 4), 1'b1);
            #1;
            checkOutput("fill_count", count, 32'(k));
            checkOutput("fill_afull", afull, (k >= 3) ? 1 : 0);
            checkOutput("fill_istop", istop, (k == 4) ? 1 : 0);
            checkOutput("fill_cdata", cdata, 16'h00A0);
            checkOutput("fill_cvalid", cvalid, 1);
            tick();
        end

        // Drain in order; A4 gets in once istop drops.
        expOut  = '{16'h00A0, 16'h00A1, 16'h00A2, 16'h00A3, 16'h00A4};
        expCnt  = '{4, 3, 3, 2, 1};
        expStop = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int k = 0; k < 5; k++) begin
            applyStimulus(k < 2, 16'h00A4, 1'b0);
            #1;
            checkOutput("drain_cdata", cdata, 32'(expOut[k]));
            checkOutput("drain_cvalid", cvalid, 1);
            checkOutput("drain_count", count, 32'(expCnt[k]));
            checkOutput("drain_istop", istop, 32'(expStop[k]));
            tick();
        end
        #1;
        checkOutput("drain_empty_count", count, 0);
        checkOutput("drain_empty_cvalid", cvalid, 0);

        // Registered instance: data appears exactly one cycle after acceptance.
        ivalid0 = 1'b1; idata0 = 16'h0055; cstop0 = 1'b0;
        #1;
        checkOutput("reg_cvalid_now", cvalid0, 0);
        checkOutput("reg_istop", istop0, 0);
        tick();
        ivalid0 = 1'b0;
        #1;
        checkOutput("reg_cvalid_next", cvalid0, 1);
        checkOutput("reg_cdata_next", cdata0, 16'h0055);
        checkOutput("reg_count_next", count0, 1);
        tick();
        #1;
        checkOutput("reg_cvalid_end", cvalid0, 0);
        checkOutput("reg_count_end", count0, 0);

        discardTest(1'b0);
        discardTest(1'b1);

        // Random traffic against a queue scoreboard; upstream holds a word until accepted.
        pending = 1'b0; sent = 0; received = 0; cycles = 0; word = 16'h0000;
        while ((sent < 1000 || sb.size() != 0) && cycles < 8000) begin
            if (!pending && sent < 1000 && $urandom_range(0, 3) != 0) begin
                pending = 1'b1;
                if (sent == 0)      word = 16'h8000;
                else if (sent == 1) word = 16'h7FFF;
                else                word = 16'($urandom);
            end
            applyStimulus(pending, word, $urandom_range(0, 2) == 0);
            #1;
            checkOutput("rnd_count", count, 32'(sb.size()));
            acc  = ivalid && !istop;
            outb = cvalid && !cstop;
            if (acc) begin
                sb.push_back(word);
                pending = 1'b0;
                sent++;
            end
            if (outb) begin
                if (sb.size() == 0) begin
                    checkOutput("rnd_spurious", 1, 0);
                end else begin
                    checkOutput("rnd_data", cdata, 32'(sb.pop_front()));
                    received++;
                end
            end
            tick();
            cycles++;
        end
        checkOutput("rnd_timeout", (cycles < 8000) ? 1 : 0, 1);
        checkOutput("rnd_received", received, 1000);
        applyStimulus(1'b0, 16'h0000, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
